mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single-port DPI memory between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). Sits between both units and the memory wrapper; serialises accesses with one outstanding transaction, round-robin grant, a request/response handshake on every side, and a response timeout watchdog.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before a forced response; range 1..65535
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU request present
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  32  IFU fetch address
- ifu_resp_valid  out  1  one-cycle IFU response strobe
- ifu_resp_data  out  32  IFU read data
- lsu_req_valid  in  1  LSU request present
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  32  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  32  write data
- lsu_req_wmask  in  4  byte write mask
- lsu_resp_valid  out  1  one-cycle LSU response strobe
- lsu_resp_data  out  32  LSU read data (write: whatever memory returns)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  latched address
- mem_req_wen  out  1  latched write enable (0 for IFU)
- mem_req_wdata  out  32  latched write data (0 for IFU)
- mem_req_wmask  out  4  latched mask (0 for IFU)
- mem_resp_valid  in  1  memory response strobe
- mem_resp_data  in  32  memory read data
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky: a WAIT timeout has occurred

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: winner = sole valid requester; if both valid, requester indicated by priority pointer. Winner's req_ready = 1 combinationally (state==IDLE && winner); loser's ready = 0. On handshake latch addr/wen/wdata/wmask and owner, flip pointer to the other requester, go ISSUE.
- Pointer resets to LSU; flips only on a grant, never on idle cycles.
- ISSUE: mem_req_valid = 1, mem_req_* from latched registers, stable until mem_req_ready; on mem_req_valid && mem_req_ready go WAIT, clear timeout counter.
- WAIT: counter increments each cycle. On mem_resp_valid: register mem_resp_data into owner's resp_data, pulse owner's resp_valid next cycle, go IDLE. If counter reaches TIMEOUT_CYCLES without response: owner's resp_data = 32'h00000000, resp_valid pulse next cycle, timeout_err set, go IDLE.
- mem_resp_valid outside WAIT is ignored (late response after timeout dropped).
- Responses have no backpressure; requesters must accept the strobe.
- resp_data holds its value until the next response for that requester.
- No request accepted while busy; req_ready = 0 in ISSUE/WAIT.

## Timing
- Reset: state IDLE, all *_ready/valid outputs 0, mem_req_* 0, resp_data 0, counter 0, pointer LSU, timeout_err 0.
- Reset mid-transaction aborts it: no response strobe, pending request lost.
- Handshake cycle T; mem_req_valid at T+1; mem_req_ready at T+1 -> WAIT at T+2; mem_resp_valid at T+2 -> resp_valid at T+3, ready for new request in same cycle T+3. Minimum round trip 3 cycles.
- mem_resp_valid in the same cycle the counter hits TIMEOUT_CYCLES: real response wins, timeout_err not set.
- Timeout response strobe at WAIT entry + TIMEOUT_CYCLES + 1.
- Back-to-back: with both valid continuously, grants alternate LSU, IFU, LSU, ...

## Test plan
- Reset, then IFU read 0x80000000, memory ready immediately, response 0x00000413 next cycle -> ifu_resp_valid at T+3 with 0x00000413, lsu_resp_valid stays 0.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x3 -> mem_req_* carries exactly those values with wen=1 until mem_req_ready (held low 4 cycles); lsu_resp_valid one cycle after mem_resp_valid.
- Both valid continuously for 6 transactions -> grant order LSU, IFU, LSU, IFU, LSU, IFU; each resp routed to correct owner.
- TIMEOUT_CYCLES=8, memory never responds -> owner resp_valid with data 0 at WAIT+9, timeout_err=1 sticky; subsequent late mem_resp_valid ignored.
- Reset asserted in WAIT -> next cycle all outputs at reset values, no resp strobe, pointer LSU, timeout_err 0.
- mem_resp_valid coincident with counter == TIMEOUT_CYCLES -> real data delivered, timeout_err remains 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch unit (IFU)
// and the load/store unit (LSU). Only one transaction is in flight at a time.
// Requests are granted round-robin, and a watchdog bounds the wait for a memory response.
//
// Ports
//   clock, reset          system clock; synchronous active-high reset
//   ifu_req_*             IFU read request (valid/ready handshake, address)
//   ifu_resp_*            IFU one-cycle response strobe and read data
//   lsu_req_*             LSU request (valid/ready, address, write enable, data, byte mask)
//   lsu_resp_*            LSU one-cycle response strobe and read data
//   mem_req_*             latched request towards memory (valid/ready handshake)
//   mem_resp_*            memory response strobe and data
//   busy                  a transaction is in progress (not IDLE)
//   timeout_err           sticky flag: a response was forced by the watchdog
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_resp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [31:0] lsu_req_wdata,
    input  logic [3:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state_reg;
    logic        ptr_lsu_reg;      // 1: LSU wins a tie, 0: IFU wins a tie
    logic        owner_lsu_reg;    // owner of the transaction in flight
    logic [31:0] addr_reg;
    logic        wen_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wmask_reg;
    logic [15:0] count_reg;
    logic        timeout_err_reg;

    // Per-requester response registers: index 0 = IFU, index 1 = LSU.
    logic        resp_valid_reg [2];
    logic [31:0] resp_data_reg  [2];

    logic        grant_lsu;
    logic        grant_ifu;
    logic        handshake;
    logic        timed_out;
    logic        resp_fire;
    logic [31:0] resp_value;

    // Arbitration. A lone requester always wins; a tie goes to the pointer.
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || ptr_lsu_reg);
    assign grant_ifu = ifu_req_valid && !grant_lsu;

    assign ifu_req_ready = (state_reg == IDLE) && grant_ifu;
    assign lsu_req_ready = (state_reg == IDLE) && grant_lsu;
    assign handshake     = ifu_req_ready || lsu_req_ready;

    // A real response takes precedence over the watchdog firing in the same cycle.
    assign timed_out  = (count_reg == TIMEOUT_LIMIT) && !mem_resp_valid;
    assign resp_fire  = (state_reg == WAIT) && (mem_resp_valid || timed_out);
    assign resp_value = mem_resp_valid ? mem_resp_data : 32'h0000_0000;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            ptr_lsu_reg     <= 1'b1;
            owner_lsu_reg   <= 1'b0;
            addr_reg        <= '0;
            wen_reg         <= 1'b0;
            wdata_reg       <= '0;
            wmask_reg       <= '0;
            count_reg       <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        owner_lsu_reg <= grant_lsu;
                        ptr_lsu_reg   <= !grant_lsu;
                        addr_reg      <= grant_lsu ? lsu_req_addr : ifu_req_addr;
                        // IFU fetches are always plain reads.
                        wen_reg       <= grant_lsu && lsu_req_wen;
                        wdata_reg     <= grant_lsu ? lsu_req_wdata : 32'h0000_0000;
                        wmask_reg     <= grant_lsu ? lsu_req_wmask : 4'h0;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        count_reg <= '0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state_reg <= IDLE;
                    end else if (timed_out) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Response path, one copy per requester. The data register keeps its value
    // between responses so the requester can read it after the strobe.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            always_ff @(posedge clock) begin
                if (reset) begin
                    resp_valid_reg[gi] <= 1'b0;
                    resp_data_reg[gi]  <= '0;
                end else begin
                    resp_valid_reg[gi] <= resp_fire && (owner_lsu_reg == 1'(gi));
                    if (resp_fire && (owner_lsu_reg == 1'(gi))) begin
                        resp_data_reg[gi] <= resp_value;
                    end
                end
            end
        end
    endgenerate

    assign ifu_resp_valid = resp_valid_reg[0];
    assign ifu_resp_data  = resp_data_reg[0];
    assign lsu_resp_valid = resp_valid_reg[1];
    assign lsu_resp_data  = resp_data_reg[1];

    assign mem_req_valid = (state_reg == ISSUE);
    assign mem_req_addr  = addr_reg;
    assign mem_req_wen   = wen_reg;
    assign mem_req_wdata = wdata_reg;
    assign mem_req_wmask = wmask_reg;

    assign busy        = (state_reg != IDLE);
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. It applies a table of transactions and then
// runs hand-written sequences for the watchdog timeout, a reset in WAIT, and a
// response that arrives in the same cycle as the timeout limit.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_data;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        busy, timeout_err;

    always #5 clock = ~clock;

    mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_data  (ifu_resp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_data  (lsu_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_ifu_data = 32'h0;
    logic [31:0] last_lsu_data = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_addr;
        logic [31:0] lsu_addr;
        logic        lsu_wen;
        logic [31:0] lsu_wdata;
        logic [3:0]  lsu_wmask;
        int          delay;      // cycles mem_req_ready is held low in ISSUE
        logic [31:0] rdata;      // data returned by memory
        logic        exp_lsu;    // expected owner: 1 = LSU, 0 = IFU
        logic [31:0] exp_addr;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
    } vec_t;

    function automatic vec_t mk(logic iv, logic lv, logic [31:0] ia, logic [31:0] la,
                                logic w, logic [31:0] wd, logic [3:0] wm, int dly,
                                logic [31:0] rd, logic el, logic [31:0] ea, logic ew,
                                logic [31:0] ewd, logic [3:0] ewm);
        vec_t v;
        v.ifu_v = iv; v.lsu_v = lv; v.ifu_addr = ia; v.lsu_addr = la;
        v.lsu_wen = w; v.lsu_wdata = wd; v.lsu_wmask = wm; v.delay = dly;
        v.rdata = rd; v.exp_lsu = el; v.exp_addr = ea; v.exp_wen = ew;
        v.exp_wdata = ewd; v.exp_wmask = ewm;
        return v;
    endfunction

    // Runs one transaction. It is called at a negedge with the DUT in IDLE and
    // returns at the negedge where the response strobe is visible. Request valids
    // are left asserted so that back-to-back rows keep requesters continuously valid.
    task automatic run_vec(input vec_t v, input string tag);
        ifu_req_valid = v.ifu_v;  ifu_req_addr  = v.ifu_addr;
        lsu_req_valid = v.lsu_v;  lsu_req_addr  = v.lsu_addr;
        lsu_req_wen   = v.lsu_wen; lsu_req_wdata = v.lsu_wdata; lsu_req_wmask = v.lsu_wmask;
        #1;
        chk({tag, " ifu_req_ready"}, ifu_req_ready, !v.exp_lsu);
        chk({tag, " lsu_req_ready"}, lsu_req_ready, v.exp_lsu);
        @(negedge clock);
        chk({tag, " issue mem_req_valid"}, mem_req_valid, 1'b1);
        chk({tag, " issue busy"}, busy, 1'b1);
        chk({tag, " issue readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
        chk({tag, " issue resp strobes"}, {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk({tag, " mem_req_addr"}, mem_req_addr, v.exp_addr);
        chk({tag, " mem_req_wen"}, mem_req_wen, v.exp_wen);
        chk({tag, " mem_req_wdata"}, mem_req_wdata, v.exp_wdata);
        chk({tag, " mem_req_wmask"}, mem_req_wmask, v.exp_wmask);
        for (int d = 0; d < v.delay; d++) begin
            @(negedge clock);
            chk({tag, " stall mem_req_valid"}, mem_req_valid, 1'b1);
            chk({tag, " stall mem_req_addr"}, mem_req_addr, v.exp_addr);
            chk({tag, " stall mem_req_wdata"}, mem_req_wdata, v.exp_wdata);
        end
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        chk({tag, " wait mem_req_valid"}, mem_req_valid, 1'b0);
        chk({tag, " wait busy"}, busy, 1'b1);
        mem_resp_valid = 1'b1;
        mem_resp_data  = v.rdata;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk({tag, " ifu_resp_valid"}, ifu_resp_valid, !v.exp_lsu);
        chk({tag, " lsu_resp_valid"}, lsu_resp_valid, v.exp_lsu);
        if (v.exp_lsu) begin
            last_lsu_data = v.rdata;
        end else begin
            last_ifu_data = v.rdata;
        end
        chk({tag, " ifu_resp_data"}, ifu_resp_data, last_ifu_data);
        chk({tag, " lsu_resp_data"}, lsu_resp_data, last_lsu_data);
        chk({tag, " done busy"}, busy, 1'b0);
    endtask

    vec_t vecs [9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // The first three rows are single-requester transactions. The last grant goes to the IFU,
        // so the pointer now favours the LSU. The six rows after them keep both requesters valid.
        vecs[0] = mk(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 32'h0000_0413,
                     0, 32'h8000_0000, 0, 32'h0, 4'h0);
        vecs[1] = mk(0, 1, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'h3, 4, 32'hCAFE_0001,
                     1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'h3);
        vecs[2] = mk(1, 0, 32'h8000_0004, 32'h0, 0, 32'h0, 4'h0, 1, 32'h0010_0093,
                     0, 32'h8000_0004, 0, 32'h0, 4'h0);
        vecs[3] = mk(1, 1, 32'h8000_0008, 32'h8000_2000, 1, 32'h1111_1111, 4'hF, 0, 32'hA0A0_A0A0,
                     1, 32'h8000_2000, 1, 32'h1111_1111, 4'hF);
        vecs[4] = mk(1, 1, 32'h8000_000C, 32'h8000_2004, 1, 32'h2222_2222, 4'h1, 2, 32'h0020_8113,
                     0, 32'h8000_000C, 0, 32'h0, 4'h0);
        vecs[5] = mk(1, 1, 32'h8000_0010, 32'h8000_2008, 0, 32'h0, 4'h0, 0, 32'h5555_AAAA,
                     1, 32'h8000_2008, 0, 32'h0, 4'h0);
        vecs[6] = mk(1, 1, 32'h8000_0014, 32'h8000_200C, 1, 32'h4444_4444, 4'hC, 1, 32'h0031_0193,
                     0, 32'h8000_0014, 0, 32'h0, 4'h0);
        vecs[7] = mk(1, 1, 32'h8000_0018, 32'h8000_2010, 1, 32'h5555_5555, 4'h8, 0, 32'h7777_7777,
                     1, 32'h8000_2010, 1, 32'h5555_5555, 4'h8);
        vecs[8] = mk(1, 1, 32'h8000_001C, 32'h8000_2014, 0, 32'h0, 4'h0, 3, 32'h0041_8213,
                     0, 32'h8000_001C, 0, 32'h0, 4'h0);

        reset = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        repeat (3) @(negedge clock);
        chk("reset busy", busy, 1'b0);
        chk("reset mem_req_valid", mem_req_valid, 1'b0);
        chk("reset mem_req_addr", mem_req_addr, 32'h0);
        chk("reset resp strobes", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk("reset timeout_err", timeout_err, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end
        ifu_req_valid = 0; lsu_req_valid = 0;

        // Watchdog timeout on an IFU read. The memory never responds.
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100;
        @(negedge clock);
        ifu_req_valid = 0;
        mem_req_ready = 1;
        @(negedge clock);
        mem_req_ready = 0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("to wait%0d ifu_resp_valid", k), ifu_resp_valid, 1'b0);
            chk($sformatf("to wait%0d timeout_err", k), timeout_err, 1'b0);
            @(negedge clock);
        end
        chk("to ifu_resp_valid", ifu_resp_valid, 1'b1);
        chk("to ifu_resp_data", ifu_resp_data, 32'h0);
        chk("to lsu_resp_valid", lsu_resp_valid, 1'b0);
        chk("to timeout_err", timeout_err, 1'b1);
        chk("to busy", busy, 1'b0);
        last_ifu_data = 32'h0;
        // A late response after the timeout must be dropped.
        mem_resp_valid = 1; mem_resp_data = 32'h1234_5678;
        @(negedge clock);
        mem_resp_valid = 0;
        chk("late resp strobes", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk("late ifu_resp_data", ifu_resp_data, 32'h0);
        chk("late busy", busy, 1'b0);
        @(negedge clock);
        chk("late resp strobes 2", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        // timeout_err stays set across a normal transaction.
        run_vec(mk(0, 1, 32'h0, 32'h8000_2100, 0, 32'h0, 4'h0, 0, 32'h0BAD_F00D,
                   1, 32'h8000_2100, 0, 32'h0, 4'h0), "sticky");
        lsu_req_valid = 0;
        chk("sticky timeout_err", timeout_err, 1'b1);

        // Reset while in WAIT aborts the transaction.
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1;
        lsu_req_wdata = 32'h9999_9999; lsu_req_wmask = 4'hF;
        @(negedge clock);
        lsu_req_valid = 0;
        mem_req_ready = 1;
        @(negedge clock);
        mem_req_ready = 0;
        chk("rst-wait busy before", busy, 1'b1);
        reset = 1; mem_resp_valid = 1; mem_resp_data = 32'h0000_0BAD;
        @(negedge clock);
        reset = 0; mem_resp_valid = 0;
        chk("rst-wait busy", busy, 1'b0);
        chk("rst-wait readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
        chk("rst-wait mem_req_valid", mem_req_valid, 1'b0);
        chk("rst-wait mem_req_addr", mem_req_addr, 32'h0);
        chk("rst-wait mem_req_wen", mem_req_wen, 1'b0);
        chk("rst-wait mem_req_wdata", mem_req_wdata, 32'h0);
        chk("rst-wait mem_req_wmask", mem_req_wmask, 4'h0);
        chk("rst-wait resp strobes", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk("rst-wait lsu_resp_data", lsu_resp_data, 32'h0);
        chk("rst-wait ifu_resp_data", ifu_resp_data, 32'h0);
        chk("rst-wait timeout_err", timeout_err, 1'b0);
        @(negedge clock);
        chk("rst-wait no strobe", {ifu_resp_valid, lsu_resp_valid}, 2'b00);

        // After reset the pointer favours the LSU. A response that arrives exactly when
        // the counter reaches the limit wins over the timeout.
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0200;
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_4000; lsu_req_wen = 0;
        lsu_req_wdata = 0; lsu_req_wmask = 0;
        #1;
        chk("ptr lsu_req_ready", lsu_req_ready, 1'b1);
        chk("ptr ifu_req_ready", ifu_req_ready, 1'b0);
        @(negedge clock);
        ifu_req_valid = 0; lsu_req_valid = 0;
        chk("coin mem_req_addr", mem_req_addr, 32'h8000_4000);
        mem_req_ready = 1;
        @(negedge clock);
        mem_req_ready = 0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("coin wait%0d lsu_resp_valid", k), lsu_resp_valid, 1'b0);
            @(negedge clock);
        end
        mem_resp_valid = 1; mem_resp_data = 32'h600D_DA7A;
        @(negedge clock);
        mem_resp_valid = 0;
        chk("coin lsu_resp_valid", lsu_resp_valid, 1'b1);
        chk("coin lsu_resp_data", lsu_resp_data, 32'h600D_DA7A);
        chk("coin ifu_resp_valid", ifu_resp_valid, 1'b0);
        chk("coin timeout_err", timeout_err, 1'b0);
        chk("coin busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
